grid_coord_capture: RTL and testbench

- Upstream feeder of the write-back stage's `grid_coord` input.
- Takes the nine raw tic-tac-toe cell buttons and synchronises and debounces them.
- Encodes one accepted press into a 4-bit cell index (0..8) and holds it until a `read_coord` instruction consumes it in write-back.
- Software polls; an empty holding register reads as the NO_COORD code.

---
 rtl/gcttt_pkg.sv | 10 +
 rtl/onehot_cell_enc.sv | 22 ++
 rtl/grid_coord_capture.sv | 115 +++++++++++
 tb/tb_grid_coord_capture.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/gcttt_pkg.sv
// Shared types and constants for the tic-tac-toe grid coordinate capture path.
package gcttt_pkg;
    localparam int NUM_CELLS = 9;

    typedef logic [3:0] coord_t;

    localparam coord_t NO_COORD = 4'hF;

    typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;
endpackage

// File: rtl/onehot_cell_enc.sv
// Combinational cell encoder: index of the set bit plus a flag that exactly one bit is set.
module onehot_cell_enc
    import gcttt_pkg::*;
#(
    parameter int NUM_BTN = NUM_CELLS
) (
    input  logic [NUM_BTN-1:0] bits,
    output coord_t             idx,
    output logic               onehot
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (bits[i]) idx = coord_t'(i);
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit value.
    assign onehot = (bits != '0) && ((bits & (bits - NUM_BTN'(1))) == '0);

endmodule

// File: rtl/grid_coord_capture.sv
// Synchronises and debounces the nine cell buttons and holds one accepted cell index for write-back.
// Define GRID_COORD_OVERRUN_EN to add the sticky 'overrun' output.
module grid_coord_capture
    import gcttt_pkg::*;
#(
    parameter int NUM_BTN         = NUM_CELLS,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               read_coord,
    input  logic               stall,
    output coord_t             grid_coord,
    output logic               coord_valid
`ifdef GRID_COORD_OVERRUN_EN
    ,
    output logic               overrun
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [NUM_BTN-1:0] sync1, btn_s, snapshot;
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    coord_t             enc_idx;
    logic               enc_onehot;
    logic               cnt_done, accept, candidate, multi, consume;

    onehot_cell_enc #(.NUM_BTN(NUM_BTN)) u_enc (
        .bits   (snapshot),
        .idx    (enc_idx),
        .onehot (enc_onehot)
    );

    assign cnt_done  = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign accept    = (state == PRESS) && (btn_s == snapshot) && cnt_done;
    assign candidate = accept & enc_onehot;
    assign multi     = accept & ~enc_onehot;
    assign consume   = read_coord & ~stall & coord_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            btn_s    <= '0;
            state    <= IDLE;
            cnt      <= '0;
            snapshot <= '0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
            case (state)
                IDLE: begin
                    if (btn_s != '0) begin
                        snapshot <= btn_s;
                        cnt      <= '0;
                        state    <= PRESS;
                    end
                end
                PRESS: begin
                    if (btn_s != snapshot) begin
                        state <= IDLE;
                    end else if (cnt_done) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // Any activity restarts the release window, so a held button stays here.
                    if (btn_s != '0) begin
                        cnt <= '0;
                    end else if (cnt_done) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coord_valid <= 1'b0;
            grid_coord  <= NO_COORD;
        end else if (candidate && (!coord_valid || consume)) begin
            coord_valid <= 1'b1;
            grid_coord  <= enc_idx;
        end else if (consume) begin
            coord_valid <= 1'b0;
            grid_coord  <= NO_COORD;
        end
    end

`ifdef GRID_COORD_OVERRUN_EN
    // A new loss in the same cycle as a consume takes priority over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (multi || (candidate && coord_valid && !consume)) begin
            overrun <= 1'b1;
        end else if (consume) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_multi;
    assign unused_multi = multi;
`endif

endmodule

// File: tb/tb_grid_coord_capture.sv
// Directed bench for grid_coord_capture with a 4-cycle debounce window.
module tb_grid_coord_capture;
    import gcttt_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [8:0]   btn;
    logic         read_coord;
    logic         stall;
    coord_t       grid_coord;
    logic         coord_valid;
`ifdef GRID_COORD_OVERRUN_EN
    logic         overrun;
`endif

    int checks = 0;
    int errors = 0;

    grid_coord_capture #(.NUM_BTN(9), .DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .read_coord  (read_coord),
        .stall       (stall),
        .grid_coord  (grid_coord),
        .coord_valid (coord_valid)
`ifdef GRID_COORD_OVERRUN_EN
        ,
        .overrun     (overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input coord_t c);
        chk({tag, "_valid"}, {31'd0, coord_valid}, {31'd0, v});
        chk({tag, "_coord"}, {28'd0, grid_coord}, {28'd0, c});
    endtask

    task automatic chk_ovr(input string tag, input logic o);
`ifdef GRID_COORD_OVERRUN_EN
        chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, o});
`else
        if (o === 1'bx) $display("unused %s", tag);
`endif
    endtask

    task automatic consume_one();
        read_coord = 1'b1;
        step(1);
        read_coord = 1'b0;
    endtask

    initial begin
        rst = 1'b1; btn = '0; read_coord = 1'b0; stall = 1'b0;
        #1;
        chk_out("reset", 1'b0, 4'hF);
        chk_ovr("reset", 1'b0);
        step(2);
        rst = 1'b0;
        step(2);

        // Clean press of cell 4: accepted on the 7th edge after the press.
        btn = 9'h010;
        step(6);
        chk_out("clean_early", 1'b0, 4'hF);
        step(1);
        chk_out("clean_accept", 1'b1, 4'd4);
        step(3);
        btn = '0;
        step(8);
        chk_out("clean_held", 1'b1, 4'd4);
        consume_one();
        chk_out("clean_consumed", 1'b0, 4'hF);

        read_coord = 1'b1;
        step(2);
        read_coord = 1'b0;
        chk_out("read_empty", 1'b0, 4'hF);

        // Bounce on cell 2 never survives long enough to be accepted.
        for (int k = 0; k < 5; k++) begin
            btn = 9'h004;
            step(2);
            btn = '0;
            step(2);
            chk("bounce_valid", {31'd0, coord_valid}, 32'd0);
        end
        btn = 9'h004;
        step(6);
        chk_out("bounce_early", 1'b0, 4'hF);
        step(1);
        chk_out("bounce_accept", 1'b1, 4'd2);
        btn = '0;
        step(8);
        consume_one();
        chk_out("bounce_consumed", 1'b0, 4'hF);
        step(10);
        chk_out("bounce_single", 1'b0, 4'hF);

        // Two cells at once are ignored.
        btn = 9'h101;
        step(10);
        chk_out("multi", 1'b0, 4'hF);
        chk_ovr("multi", 1'b1);
        btn = '0;
        step(8);

        // Full register drops a new press.
        btn = 9'h010;
        step(7);
        chk_out("full_first", 1'b1, 4'd4);
        btn = '0;
        step(8);
        btn = 9'h100;
        step(8);
        chk_out("full_drop", 1'b1, 4'd4);
        chk_ovr("full_drop", 1'b1);
        btn = '0;
        step(8);

        // Consume on the acceptance edge hands over without a gap.
        btn = 9'h100;
        step(6);
        chk_out("handover_pre", 1'b1, 4'd4);
        consume_one();
        chk_out("handover", 1'b1, 4'd8);
        chk_ovr("handover", 1'b0);
        btn = '0;
        step(8);
        consume_one();
        chk_out("handover_consumed", 1'b0, 4'hF);

        // Stall holds the read from retiring.
        btn = 9'h040;
        step(7);
        chk_out("stall_accept", 1'b1, 4'd6);
        btn = '0;
        step(8);
        read_coord = 1'b1; stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk_out("stall_hold", 1'b1, 4'd6);
        end
        stall = 1'b0;
        step(1);
        read_coord = 1'b0;
        chk_out("stall_release", 1'b0, 4'hF);

        // Async reset while full and mid-press discards both.
        btn = 9'h002;
        step(7);
        chk_out("rst_pre", 1'b1, 4'd1);
        btn = '0;
        step(8);
        btn = 9'h008;
        step(4);
        rst = 1'b1;
        #1;
        chk_out("rst_async", 1'b0, 4'hF);
        step(1);
        rst = 1'b0;
        step(6);
        chk_out("rst_restart_early", 1'b0, 4'hF);
        step(1);
        chk_out("rst_restart", 1'b1, 4'd3);
        btn = '0;
        step(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
